// File: rtl/cruce_controlador.sv
// Demand-actuated two-approach crossing sequencer.
// Approach A rests in green; approach B is served for a fixed green after a request.
// Every change of right-of-way goes through yellow and then an all-red clearance.
module cruce_controlador #(
  parameter int unsigned T_MIN_VERDE = 6,
  parameter int unsigned T_VERDE_B   = 10,
  parameter int unsigned T_AMARILLO  = 3,
  parameter int unsigned T_TODO_ROJO = 2,
  parameter int unsigned CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       sensor_B,
  input  logic       ped_req_A,
  output logic [1:0] semaforo_A,
  output logic [1:0] semaforo_B,
  output logic [2:0] estado,
  output logic       demanda_pend
);

  typedef enum logic [2:0] {
    A_VERDE    = 3'd0,
    A_AMARILLO = 3'd1,
    ROJO_AB    = 3'd2,
    B_VERDE    = 3'd3,
    B_AMARILLO = 3'd4,
    ROJO_BA    = 3'd5
  } estado_t;

  localparam logic [1:0] LUZ_ROJO     = 2'b00;
  localparam logic [1:0] LUZ_AMARILLO = 2'b01;
  localparam logic [1:0] LUZ_VERDE    = 2'b10;

  // Last timer value of each phase (phase of length T ends when timer == T-1)
  localparam logic [CW-1:0] FIN_MIN_VERDE = CW'(T_MIN_VERDE - 1);
  localparam logic [CW-1:0] FIN_VERDE_B   = CW'(T_VERDE_B - 1);
  localparam logic [CW-1:0] FIN_AMARILLO  = CW'(T_AMARILLO - 1);
  localparam logic [CW-1:0] FIN_TODO_ROJO = CW'(T_TODO_ROJO - 1);
  localparam logic [CW-1:0] TIMER_MAX     = {CW{1'b1}};

  logic [CW-1:0] timer;
  logic [2:0]    estado_nxt;
  logic          cambio;
  logic          demanda;
  logic          set_dem;
  logic          clr_dem;
  logic [1:0]    luz_a_nxt;
  logic [1:0]    luz_b_nxt;

  // Next-state, demand latch control and light decode of the next state
  always_comb begin
    estado_nxt = estado;
    luz_a_nxt  = LUZ_ROJO;
    luz_b_nxt  = LUZ_ROJO;
    demanda    = demanda_pend | sensor_B | ped_req_A;

    case (estado)
      A_VERDE:    if (timer >= FIN_MIN_VERDE && demanda) estado_nxt = A_AMARILLO;
      A_AMARILLO: if (timer == FIN_AMARILLO)             estado_nxt = ROJO_AB;
      ROJO_AB:    if (timer == FIN_TODO_ROJO)            estado_nxt = B_VERDE;
      B_VERDE:    if (timer == FIN_VERDE_B)              estado_nxt = B_AMARILLO;
      B_AMARILLO: if (timer == FIN_AMARILLO)             estado_nxt = ROJO_BA;
      ROJO_BA:    if (timer == FIN_TODO_ROJO)            estado_nxt = A_VERDE;
      default:                                           estado_nxt = ROJO_BA;
    endcase

    // No state loops onto itself, so any difference is a transition
    cambio = (estado_nxt != estado);

    case (estado_nxt)
      A_VERDE:    luz_a_nxt = LUZ_VERDE;
      A_AMARILLO: luz_a_nxt = LUZ_AMARILLO;
      B_VERDE:    luz_b_nxt = LUZ_VERDE;
      B_AMARILLO: luz_b_nxt = LUZ_AMARILLO;
      default: begin
        luz_a_nxt = LUZ_ROJO;
        luz_b_nxt = LUZ_ROJO;
      end
    endcase

    // Requests are latched even while frozen, but not while B is being served
    set_dem = (sensor_B | ped_req_A) && (estado != B_VERDE) && (estado != B_AMARILLO);
    clr_dem = enb && (estado == ROJO_AB) && (estado_nxt == B_VERDE);
  end

  // State, timer, demand latch and registered light outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= ROJO_BA;
      timer        <= '0;
      demanda_pend <= 1'b0;
      semaforo_A   <= LUZ_ROJO;
      semaforo_B   <= LUZ_ROJO;
    end else begin
      demanda_pend <= clr_dem ? 1'b0 : (demanda_pend | set_dem);
      if (enb) begin
        estado     <= estado_nxt;
        semaforo_A <= luz_a_nxt;
        semaforo_B <= luz_b_nxt;
        if (cambio)
          timer <= '0;
        else if (timer != TIMER_MAX)
          timer <= timer + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cruce_controlador.sv
// Directed bench for the crossing sequencer, cycle-numbered from reset release.
module tb_cruce_controlador;

  logic       clk;
  logic       reset;
  logic       enb;
  logic       sensor_B;
  logic       ped_req_A;
  logic [1:0] semaforo_A;
  logic [1:0] semaforo_B;
  logic [2:0] estado;
  logic       demanda_pend;

  int total;
  int bad;
  logic en_reset;

  cruce_controlador dut (
    .clk          (clk),
    .reset        (reset),
    .enb          (enb),
    .sensor_B     (sensor_B),
    .ped_req_A    (ped_req_A),
    .semaforo_A   (semaforo_A),
    .semaforo_B   (semaforo_B),
    .estado       (estado),
    .demanda_pend (demanda_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Both approaches must never be non-red together; code 11 never appears
  always @(negedge clk) begin
    if (!en_reset) begin
      check("safe_both", 32'((semaforo_A != 2'b00) && (semaforo_B != 2'b00)), 32'd0);
      check("safe_code", 32'((semaforo_A == 2'b11) || (semaforo_B == 2'b11)), 32'd0);
    end
  end

  // Reset held 3 cycles; returns at the start of cycle 0 with reset low
  task automatic do_reset();
    en_reset  = 1'b1;
    reset     = 1'b1;
    enb       = 1'b1;
    sensor_B  = 1'b0;
    ped_req_A = 1'b0;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    en_reset = 1'b0;
  endtask

  // Check n consecutive cycles against one expected state/lights/demand
  task automatic run(input string tag, input int n, input int st, input int a,
                     input int b, input int dm);
    for (int i = 0; i < n; i++) begin
      check({tag, "_estado"}, 32'(estado), 32'(st));
      check({tag, "_A"}, 32'(semaforo_A), 32'(a));
      check({tag, "_B"}, 32'(semaforo_B), 32'(b));
      check({tag, "_dem"}, 32'(demanda_pend), 32'(dm));
      @(negedge clk);
    end
  endtask

  // Common prefix: sensor_B pulse at cycle 4, stops at start of cycle 13 (B_VERDE)
  task automatic to_b_verde(input string tag);
    run({tag, "_rba"}, 2, 5, 0, 0, 0);
    run({tag, "_av"}, 2, 0, 2, 0, 0);
    sensor_B = 1'b1;
    run({tag, "_av4"}, 1, 0, 2, 0, 0);
    sensor_B = 1'b0;
    run({tag, "_avd"}, 3, 0, 2, 0, 1);
    run({tag, "_aam"}, 3, 1, 1, 0, 1);
    run({tag, "_rab"}, 2, 2, 0, 0, 1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    en_reset = 1'b1;
    reset    = 1'b1;
    enb      = 1'b1;
    sensor_B = 1'b0;
    ped_req_A = 1'b0;

    // Idle: rest in A green indefinitely
    do_reset();
    run("s1_rba", 2, 5, 0, 0, 0);
    run("s1_av", 199, 0, 2, 0, 0);

    // sensor_B service, then ped_req_A service, then ignored request in B green
    do_reset();
    to_b_verde("s2");
    run("s2_bv", 10, 3, 0, 2, 0);
    run("s2_bam", 3, 4, 0, 1, 0);
    run("s2_rba", 2, 5, 0, 0, 0);
    run("s2_av28", 2, 0, 2, 0, 0);
    ped_req_A = 1'b1;
    run("s2_av30", 1, 0, 2, 0, 0);
    ped_req_A = 1'b0;
    run("s2_avp", 3, 0, 2, 0, 1);
    run("s2_aam2", 3, 1, 1, 0, 1);
    run("s2_rab2", 2, 2, 0, 0, 1);
    run("s2_bv2a", 2, 3, 0, 2, 0);
    ped_req_A = 1'b1;
    run("s2_bv2p", 1, 3, 0, 2, 0);
    ped_req_A = 1'b0;
    run("s2_bv2b", 7, 3, 0, 2, 0);
    run("s2_bam2", 3, 4, 0, 1, 0);
    run("s2_rba2", 2, 5, 0, 0, 0);
    run("s2_avend", 20, 0, 2, 0, 0);

    // Freeze during B green; sensor_B while frozen in B green is ignored
    do_reset();
    to_b_verde("s3");
    run("s3_bv", 2, 3, 0, 2, 0);
    enb = 1'b0;
    run("s3_frz15", 1, 3, 0, 2, 0);
    sensor_B = 1'b1;
    run("s3_frz16", 1, 3, 0, 2, 0);
    sensor_B = 1'b0;
    run("s3_frz17", 3, 3, 0, 2, 0);
    enb = 1'b1;
    run("s3_bvres", 8, 3, 0, 2, 0);
    run("s3_bam", 3, 4, 0, 1, 0);
    run("s3_rba", 2, 5, 0, 0, 0);
    run("s3_av", 8, 0, 2, 0, 0);

    // Reset in the middle of B green aborts the phase
    do_reset();
    to_b_verde("s4");
    run("s4_bv", 4, 3, 0, 2, 0);
    reset = 1'b1;
    run("s4_bv17", 1, 3, 0, 2, 0);
    reset = 1'b0;
    run("s4_rba", 2, 5, 0, 0, 0);
    run("s4_av", 6, 0, 2, 0, 0);

    // Request while frozen in A green is latched and served on resume
    do_reset();
    run("s5_rba", 2, 5, 0, 0, 0);
    run("s5_av", 8, 0, 2, 0, 0);
    enb = 1'b0;
    sensor_B = 1'b1;
    run("s5_frz10", 1, 0, 2, 0, 0);
    sensor_B = 1'b0;
    run("s5_frz", 3, 0, 2, 0, 1);
    enb = 1'b1;
    run("s5_av14", 1, 0, 2, 0, 1);
    run("s5_aam", 3, 1, 1, 0, 1);

    // Illegal state code recovers to all-red clearance
    do_reset();
    run("s6_rba", 2, 5, 0, 0, 0);
    run("s6_av", 3, 0, 2, 0, 0);
    force dut.estado = 3'd7;
    #1;
    release dut.estado;
    @(negedge clk);
    run("s6_ill", 2, 5, 0, 0, 0);
    run("s6_av2", 3, 0, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit in case the run ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
